// File: rtl/apb_requester.sv
// rtl/apb_requester.sv - APB requester turning valid/ready commands into single APB transfers
// One transfer in flight; responses carry read data or a timeout error.
module apb_requester #(
    parameter int ADDR_W           = 32,
    parameter int DATA_W           = 32,
    parameter int RD_CAPTURE_DELAY = 1,
    parameter int TIMEOUT_CYCLES   = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata
);

    localparam int TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int RC_W = (RD_CAPTURE_DELAY > 1) ? $clog2(RD_CAPTURE_DELAY + 1) : 1;
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
    localparam logic [RC_W-1:0] RC_LAST  = RC_W'((RD_CAPTURE_DELAY > 0) ? RD_CAPTURE_DELAY - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        RCAP,
        RESP
    } state_t;

    state_t            state, state_n;
    logic              psel_n, penable_n, pwrite_n;
    logic [ADDR_W-1:0] paddr_n;
    logic [DATA_W-1:0] pwdata_n;
    logic              rsp_valid_n, rsp_err_n;
    logic [DATA_W-1:0] rsp_rdata_n;
    logic [TO_W-1:0]   to_cnt, to_cnt_n, to_cnt_inc;
    logic [RC_W-1:0]   rc_cnt, rc_cnt_n;

    assign cmd_ready = (state == IDLE);

    // Saturating increment so a disabled or long timeout never wraps back to zero.
    assign to_cnt_inc = (to_cnt == '1) ? to_cnt : to_cnt + 1'b1;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state     <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            to_cnt    <= '0;
            rc_cnt    <= '0;
        end else begin
            state     <= state_n;
            psel      <= psel_n;
            penable   <= penable_n;
            pwrite    <= pwrite_n;
            paddr     <= paddr_n;
            pwdata    <= pwdata_n;
            rsp_valid <= rsp_valid_n;
            rsp_err   <= rsp_err_n;
            rsp_rdata <= rsp_rdata_n;
            to_cnt    <= to_cnt_n;
            rc_cnt    <= rc_cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        psel_n      = psel;
        penable_n   = penable;
        pwrite_n    = pwrite;
        paddr_n     = paddr;
        pwdata_n    = pwdata;
        rsp_valid_n = rsp_valid;
        rsp_err_n   = rsp_err;
        rsp_rdata_n = rsp_rdata;
        to_cnt_n    = to_cnt;
        rc_cnt_n    = rc_cnt;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    paddr_n  = cmd_addr;
                    pwrite_n = cmd_write;
                    pwdata_n = cmd_wdata;
                    psel_n   = 1'b1;
                    to_cnt_n = '0;
                    state_n  = SETUP;
                end
            end
            SETUP: begin
                penable_n = 1'b1;
                state_n   = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    psel_n    = 1'b0;
                    penable_n = 1'b0;
                    rsp_err_n = 1'b0;
                    if (pwrite) begin
                        rsp_rdata_n = '0;
                        rsp_valid_n = 1'b1;
                        state_n     = RESP;
                    end else if (RD_CAPTURE_DELAY == 0) begin
                        rsp_rdata_n = prdata;
                        rsp_valid_n = 1'b1;
                        state_n     = RESP;
                    end else begin
                        rc_cnt_n = '0;
                        state_n  = RCAP;
                    end
                end else begin
                    to_cnt_n = to_cnt_inc;
                    if ((TIMEOUT_CYCLES != 0) && (to_cnt_inc >= TO_LIMIT)) begin
                        psel_n      = 1'b0;
                        penable_n   = 1'b0;
                        rsp_err_n   = 1'b1;
                        rsp_rdata_n = '0;
                        rsp_valid_n = 1'b1;
                        state_n     = RESP;
                    end
                end
            end
            RCAP: begin
                // Registered-read slaves present data the cycle after the access completes.
                if (rc_cnt == RC_LAST) begin
                    rsp_rdata_n = prdata;
                    rsp_valid_n = 1'b1;
                    state_n     = RESP;
                end else begin
                    rc_cnt_n = rc_cnt + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    rsp_err_n   = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_requester.sv
// tb/tb_apb_requester.sv - randomized bench for apb_requester against a register-map model
module tb_apb_requester;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int RCD = 1;
    localparam int TO  = 16;

    logic          pclk = 1'b0;
    logic          presetn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pwrite;
    logic          psel;
    logic          penable;
    logic          pready;
    logic [DW-1:0] prdata = '0;

    always #5 pclk = ~pclk;

    apb_requester #(
        .ADDR_W(AW), .DATA_W(DW), .RD_CAPTURE_DELAY(RCD), .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
        .pready(pready), .prdata(prdata)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bus-side register file: word 1 read-only ID, word 5 unmapped, others read/write.
    logic [DW-1:0] slave_mem [8] = '{default: '0};
    int            acc_cnt = 0;
    int            wait_cycles = 0;
    bit            hold_low = 1'b0;

    assign pready = !hold_low && (acc_cnt >= wait_cycles);

    always @(posedge pclk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
        if (psel && penable && pready) begin
            if (pwrite) begin
                if (paddr[4:2] != 3'd1 && paddr[4:2] != 3'd5) slave_mem[paddr[4:2]] <= pwdata;
                prdata <= $urandom;
            end else begin
                prdata <= (paddr[4:2] == 3'd1) ? 32'h5A5A5555 :
                          (paddr[4:2] == 3'd5) ? 32'h0 : slave_mem[paddr[4:2]];
            end
        end else begin
            prdata <= $urandom;
        end
    end

    // Expected register contents, updated from the command stream alone.
    logic [DW-1:0] model_mem [8];

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        if (a[4:2] == 3'd1) return 32'h5A5A5555;
        if (a[4:2] == 3'd5) return 32'h0;
        return model_mem[a[4:2]];
    endfunction

    task automatic do_xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input int waits, input int hold, input bit expect_to);
        int            k, n_psel, n_pen, lat, exp_lat;
        bit            bus_ok, busy_ok, stable;
        logic [DW-1:0] exp_rd, held;
        exp_rd = (wr || expect_to) ? '0 : model_read(addr);
        if (wr && !expect_to && addr[4:2] != 3'd1 && addr[4:2] != 3'd5) model_mem[addr[4:2]] = wdata;
        exp_lat = expect_to ? 2 + TO : 3 + waits + (wr ? 0 : RCD);
        wait_cycles = waits;
        hold_low    = expect_to;
        cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 50) begin @(negedge pclk); k++; end
        check("accept_ready", cmd_ready, 1'b1);
        @(posedge pclk);
        @(negedge pclk);
        cmd_valid = 1'b0;
        n_psel = 0; n_pen = 0; lat = 0; bus_ok = 1'b1; busy_ok = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            if (c > 1) @(negedge pclk);
            if (rsp_valid) begin lat = c; break; end
            if (psel) begin
                n_psel++;
                if (paddr !== addr || pwrite !== wr || (wr && pwdata !== wdata)) bus_ok = 1'b0;
            end
            if (penable) n_pen++;
            if (cmd_ready) busy_ok = 1'b0;
        end
        check("latency", lat, exp_lat);
        check("psel_cycles", n_psel, expect_to ? 1 + TO : 2 + waits);
        check("penable_cycles", n_pen, expect_to ? TO : 1 + waits);
        check("bus_fields", bus_ok, 1'b1);
        check("busy_no_ready", busy_ok, 1'b1);
        check("rsp_idle_bus", {psel, penable, cmd_ready}, 3'b000);
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("rsp_err", rsp_err, expect_to);
        held = rsp_rdata; stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge pclk);
            if (!rsp_valid || rsp_rdata !== held || rsp_err !== expect_to || cmd_ready) stable = 1'b0;
        end
        if (hold > 0) check("hold_stable", stable, 1'b1);
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        check("rsp_cleared", {rsp_valid, rsp_err, cmd_ready}, 3'b001);
        hold_low = 1'b0;
    endtask

    task automatic reset_mid_access(input logic [AW-1:0] addr);
        int k;
        bit quiet;
        hold_low = 1'b1;
        cmd_write = 1'b0; cmd_addr = addr; cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 50) begin @(negedge pclk); k++; end
        @(posedge pclk);
        @(negedge pclk);
        cmd_valid = 1'b0;
        k = 0;
        while (!penable && k < 10) begin @(negedge pclk); k++; end
        check("rst_reached_access", penable, 1'b1);
        #2 presetn = 1'b0;
        #1 check("rst_async_drop", {psel, penable, rsp_valid}, 3'b000);
        @(negedge pclk);
        presetn  = 1'b1;
        hold_low = 1'b0;
        @(negedge pclk);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid || psel) quiet = 1'b0;
            @(negedge pclk);
        end
        check("rst_no_response", quiet, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit");
        $fatal(1);
    end

    initial begin
        bit            wr;
        logic [AW-1:0] a;
        for (int i = 0; i < 8; i++) model_mem[i] = '0;
        repeat (3) @(negedge pclk);
        check("reset_apb", {psel, penable, pwrite}, 3'b000);
        check("reset_paddr_pwdata", {paddr, pwdata}, 64'h0);
        check("reset_rsp", {rsp_valid, rsp_err}, 2'b00);
        check("reset_rdata", rsp_rdata, 32'h0);
        presetn = 1'b1;
        @(negedge pclk);
        check("reset_cmd_ready", cmd_ready, 1'b1);

        do_xfer(1'b0, 32'h4,  32'h0,        0, 0, 1'b0);
        do_xfer(1'b1, 32'h8,  32'hDEADBEEF, 0, 0, 1'b0);
        do_xfer(1'b0, 32'h8,  32'h0,        0, 0, 1'b0);
        do_xfer(1'b1, 32'h0,  32'h0000000F, 0, 0, 1'b0);
        do_xfer(1'b0, 32'h0,  32'h0,        0, 0, 1'b0);
        do_xfer(1'b1, 32'h4,  32'hFFFFFFFF, 0, 0, 1'b0);
        do_xfer(1'b0, 32'h4,  32'h0,        0, 0, 1'b0);
        do_xfer(1'b0, 32'h14, 32'h0,        0, 0, 1'b0);
        do_xfer(1'b0, 32'h8,  32'h0,        0, 0, 1'b1);
        do_xfer(1'b1, 32'hC,  32'h12345678, 0, 0, 1'b1);
        do_xfer(1'b0, 32'hC,  32'h0,        0, 0, 1'b0);
        do_xfer(1'b1, 32'hC,  32'hCAFEF00D, 2, 0, 1'b0);
        do_xfer(1'b0, 32'hC,  32'h0,        0, 5, 1'b0);
        reset_mid_access(32'h8);
        do_xfer(1'b0, 32'h8,  32'h0,        0, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            wr = 1'($urandom_range(0, 1));
            a  = {27'h0, 3'($urandom_range(0, 7)), 2'b00};
            do_xfer(wr, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
- APB requester (initiator) that converts a simple valid/ready command interface into single APB transfers.
- Returns write completions and read data on a response channel.
- Drives the codebase's APB register-file slaves. Those slaves register read data at the end of the access phase, so the requester captures prdata after a configurable delay.
- Sits between the test/CPU-side command source and the APB bus; one outstanding transfer at a time.

Parameters:
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width.
- RD_CAPTURE_DELAY, 1, cycles after access completion before sampling prdata (0 = sample on completing edge; 1 = sample one cycle later, for registered-read slaves).
- TIMEOUT_CYCLES, 16, maximum access-phase cycles waiting for pready before abort; 0 disables timeout.

Ports:
- pclk  in  1  APB clock; all logic on rising edge.
- presetn  in  1  reset; one clock; reset is asynchronous and active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  requester can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  transfer address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumer ready.
- rsp_rdata  out  DATA_W  read data (0 for writes and errors).
- rsp_err  out  1  transfer aborted by timeout.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- pwrite  out  1  APB direction.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pready  in  1  APB ready; tie 1 for slaves without wait states.
- prdata  in  DATA_W  APB read data.

Behaviour:
- Reset (async assert, sync deassert to state machine):
  - State IDLE.
  - psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_err, rsp_rdata, timeout counter all 0.
  - cmd_ready = 1 in the first cycle after release.
- All APB outputs and rsp_* are registered.
- States:
  - IDLE: cmd_ready = 1. On cmd_valid && cmd_ready, latch write/addr/wdata into paddr/pwrite/pwdata, set psel = 1, go to SETUP.
  - SETUP: psel = 1, penable = 0, exactly one cycle; then penable = 1, go to ACCESS.
  - ACCESS: psel = 1, penable = 1; paddr/pwrite/pwdata stable. Each cycle with pready = 0 increments the timeout counter.
    - On pready = 1: drop psel and penable on the next edge.
    - Write completion: go to RESP with rsp_rdata = 0, rsp_err = 0.
    - Read, RD_CAPTURE_DELAY = 0: capture prdata on the completing edge, go to RESP.
    - Read, RD_CAPTURE_DELAY = 1: go to RCAP.
    - If TIMEOUT_CYCLES ≠ 0 and the counter reaches TIMEOUT_CYCLES with pready still 0: drop psel/penable, rsp_err = 1, rsp_rdata = 0, go to RESP.
  - RCAP: psel = 0, penable = 0; capture prdata into rsp_rdata at end of cycle, go to RESP.
  - RESP: rsp_valid = 1, held with stable rsp_rdata/rsp_err until rsp_ready = 1. Then clear rsp_valid and rsp_err, go to IDLE.
- cmd_ready = 0 in every state except IDLE. Commands are never accepted while a response is pending.
- Latency from command accept to rsp_valid, with pready = 1:
  - Write: 3 cycles.
  - Read: 3 + RD_CAPTURE_DELAY cycles.
- Minimum back-to-back period: 4 cycles (write) or 4 + RD_CAPTURE_DELAY cycles (read).
- paddr/pwdata/pwrite hold their last values outside transfers; not cleared.
- Timeout counter clears on every entry to SETUP and saturates; it never wraps.
- rsp_ready asserted while not in RESP is ignored. cmd_valid while cmd_ready = 0 is ignored; the source must hold the command.
- Reset asserted mid-transfer: APB outputs drop to 0 immediately and asynchronously; the transfer is lost and no response is produced.

Test Plan:
- After reset, read addr 0x4 with pready = 1, RD_CAPTURE_DELAY = 1 -> psel 1 for 2 cycles, penable 1 for 1 cycle; rsp_valid 4 cycles after accept; rsp_rdata = 0x5A5A5555, rsp_err = 0.
- Write 0x8 = 0xDEADBEEF, then read 0x8 -> write response after 3 cycles with rsp_rdata = 0; read returns 0xDEADBEEF. Write 0x0 = 0xF, read 0x0 -> 0x0000000F.
- Write 0x4 = 0xFFFFFFFF, then read 0x4 -> 0x5A5A5555 (read-only register). Read 0x14 -> 0x00000000, rsp_err = 0.
- pready held 0 with TIMEOUT_CYCLES = 16 -> psel/penable drop after 16 access cycles; rsp_err = 1, rsp_rdata = 0; next command is accepted normally.
- rsp_ready held 0 for 5 cycles after a read -> rsp_valid and rsp_rdata stable; cmd_ready = 0 throughout; IDLE is reached the cycle after rsp_ready = 1.
- presetn pulsed low during ACCESS -> psel/penable = 0 without a clock edge; no rsp_valid; cmd_ready = 1 after release.
